// File: rtl/fc_pkg.sv
// Shared types for the fully-connected layer scheduler: FSM states,
// weight-port owner encoding and the default weight address width.
package fc_pkg;

    localparam int ADDR_W_DEF = 15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        OWN_L1 = 1'b0,
        OWN_L2 = 1'b1
    } owner_t;

endpackage

// File: rtl/fc_layer_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority
// that flips to the other requester after every grant.
module rr_arb2
    import fc_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req1,
    input  logic   req2,
    output logic   gnt1,
    output logic   gnt2,
    output owner_t owner
);

    owner_t prio;

    assign gnt1  = req1 && (!req2 || prio == OWN_L1);
    assign gnt2  = req2 && !gnt1;
    assign owner = gnt2 ? OWN_L2 : OWN_L1;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= OWN_L1;
        end else if (gnt1) begin
            prio <= OWN_L2;
        end else if (gnt2) begin
            prio <= OWN_L1;
        end
    end

endmodule

// File: rtl/fc_layer_sched.sv
// Two-layer FC frame scheduler with hand-off slot and shared weight port.
// Optional per-layer watchdog: define FC_LAYER_SCHED_WATCHDOG_EN.
module fc_layer_sched
    import fc_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_in,
    output logic              start_rdy,
    output logic              fc1_start,
    output logic              fc1_mode,
    input  logic              fc1_done,
    output logic              fc2_start,
    output logic              fc2_mode,
    input  logic              fc2_done,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    input  logic              req2,
    input  logic [ADDR_W-1:0] addr2,
    output logic              gnt2,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic              rd_vld,
    output logic              rd_owner,
    output logic              frame_done,
    output logic              err
);

    if (RD_LAT < 1 || RD_LAT > 3 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("fc_layer_sched: RD_LAT must be 1..3, TIMEOUT_CYC >= 2");
    end

    state_t l1_st;
    state_t l2_st;
    logic   hv;
    logic   hmode;
    logic   fc2_mode_q;
    logic   l1_to;
    logic   l2_to;

    assign start_rdy = (l1_st == ST_IDLE) && !hv;
    // Slot is drained in the very cycle it is seen, so fc2 launch is combinational
    assign fc2_start = hv && (l2_st == ST_IDLE);
    assign fc2_mode  = fc2_start ? hmode : fc2_mode_q;

`ifdef FC_LAYER_SCHED_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] l1_cnt;
    logic [CW-1:0] l2_cnt;
    logic          err_q;

    assign l1_to = (l1_st == ST_RUN) && !fc1_done
                && (l1_cnt == CW'(TIMEOUT_CYC - 1));
    assign l2_to = (l2_st == ST_RUN) && !fc2_done
                && (l2_cnt == CW'(TIMEOUT_CYC - 1));
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            l1_cnt <= '0;
            l2_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            l1_cnt <= (l1_st == ST_RUN) ? l1_cnt + 1'b1 : '0;
            l2_cnt <= (l2_st == ST_RUN) ? l2_cnt + 1'b1 : '0;
            if (l1_to || l2_to) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign l1_to = 1'b0;
    assign l2_to = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            l1_st     <= ST_IDLE;
            fc1_start <= 1'b0;
            fc1_mode  <= 1'b0;
        end else begin
            fc1_start <= 1'b0;
            case (l1_st)
                ST_IDLE: begin
                    if (start && start_rdy) begin
                        l1_st     <= ST_RUN;
                        fc1_start <= 1'b1;
                        fc1_mode  <= mode_in;
                    end
                end
                ST_RUN: begin
                    if (fc1_done || l1_to) begin
                        l1_st <= ST_IDLE;
                    end
                end
                default: l1_st <= ST_IDLE;
            endcase
        end
    end

    // A fill wins over a drain in the same cycle, so no frame is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            hv    <= 1'b0;
            hmode <= 1'b0;
        end else if ((l1_st == ST_RUN) && fc1_done) begin
            hv    <= 1'b1;
            hmode <= fc1_mode;
        end else if (fc2_start) begin
            hv    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l2_st      <= ST_IDLE;
            fc2_mode_q <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (l2_st)
                ST_IDLE: begin
                    if (hv) begin
                        l2_st      <= ST_RUN;
                        fc2_mode_q <= hmode;
                    end
                end
                ST_RUN: begin
                    if (fc2_done) begin
                        l2_st      <= ST_IDLE;
                        frame_done <= 1'b1;
                    end else if (l2_to) begin
                        l2_st      <= ST_IDLE;
                    end
                end
                default: l2_st <= ST_IDLE;
            endcase
        end
    end

    owner_t gnt_own;
    logic   w_own;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req1  (req1),
        .req2  (req2),
        .gnt1  (gnt1),
        .gnt2  (gnt2),
        .owner (gnt_own)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            w_en   <= 1'b0;
            w_addr <= '0;
            w_own  <= 1'b0;
        end else begin
            w_en  <= gnt1 || gnt2;
            w_own <= gnt_own;
            if (gnt1) begin
                w_addr <= addr1;
            end else if (gnt2) begin
                w_addr <= addr2;
            end
        end
    end

    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] own_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            own_sr <= '0;
        end else begin
            vld_sr[0] <= w_en;
            own_sr[0] <= w_own;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                own_sr[i] <= own_sr[i-1];
            end
        end
    end

    assign rd_vld   = vld_sr[RD_LAT-1];
    assign rd_owner = own_sr[RD_LAT-1];

endmodule

// File: tb/tb_fc_layer_sched.sv
// Bench for fc_layer_sched: directed frame/overlap/reset steps plus
// randomized frame flow and weight-port traffic against a queue model.
module tb_fc_layer_sched;

    localparam int AW  = 15;
    localparam int LAT = 2;
    localparam int N   = 150;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode_in;
    logic          start_rdy;
    logic          fc1_start;
    logic          fc1_mode;
    logic          fc1_done;
    logic          fc2_start;
    logic          fc2_mode;
    logic          fc2_done;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          gnt1;
    logic          req2;
    logic [AW-1:0] addr2;
    logic          gnt2;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic          rd_vld;
    logic          rd_owner;
    logic          frame_done;
    logic          err;

    int errs   = 0;
    int checks = 0;

    fc_layer_sched #(
        .ADDR_W      (AW),
        .RD_LAT      (LAT),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode_in    (mode_in),
        .start_rdy  (start_rdy),
        .fc1_start  (fc1_start),
        .fc1_mode   (fc1_mode),
        .fc1_done   (fc1_done),
        .fc2_start  (fc2_start),
        .fc2_mode   (fc2_mode),
        .fc2_done   (fc2_done),
        .req1       (req1),
        .addr1      (addr1),
        .gnt1       (gnt1),
        .req2       (req2),
        .addr2      (addr2),
        .gnt2       (gnt2),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .rd_vld     (rd_vld),
        .rd_owner   (rd_owner),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start_rdy"}, 32'(start_rdy), 1);
        chk({tag, "_fc1_start"}, 32'(fc1_start), 0);
        chk({tag, "_fc2_start"}, 32'(fc2_start), 0);
        chk({tag, "_gnt"}, {30'd0, gnt1, gnt2}, 0);
        chk({tag, "_w_en"}, 32'(w_en), 0);
        chk({tag, "_rd_vld"}, 32'(rd_vld), 0);
        chk({tag, "_rd_owner"}, 32'(rd_owner), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_modes"}, {30'd0, fc1_mode, fc2_mode}, 0);
        chk({tag, "_w_addr"}, 32'(w_addr), 0);
    endtask

    // model state
    logic        mq[$];
    logic        m;
    int          n_start;
    int          n_done;
    bit          l1b;
    bit          l2b;
    int          c1;
    int          c2;
    int          last_g;
    logic        g1;
    logic        g2;
    logic        exp_wen[0:N+LAT+4];
    logic        exp_vld[0:N+LAT+4];
    logic        exp_own[0:N+LAT+4];
    logic [AW-1:0] exp_wa[0:N+LAT+4];

    initial begin
        rst = 1'b1; start = 0; mode_in = 0;
        fc1_done = 0; fc2_done = 0;
        req1 = 0; req2 = 0; addr1 = '0; addr2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk_reset_vals("reset");

        // single frame, mode 1
        tick();
        start = 1; mode_in = 1;
        #1;
        chk("single_rdy", 32'(start_rdy), 1);
        tick();
        start = 0; mode_in = 0;
        chk("single_fc1_start", 32'(fc1_start), 1);
        chk("single_fc1_mode", 32'(fc1_mode), 1);
        chk("single_busy", 32'(start_rdy), 0);
        tick();
        chk("single_fc1_pulse", 32'(fc1_start), 0);
        fc1_done = 1;
        tick();
        fc1_done = 0;
        #1;
        chk("single_fc2_start", 32'(fc2_start), 1);
        chk("single_fc2_mode", 32'(fc2_mode), 1);
        tick();
        chk("single_fc2_pulse", 32'(fc2_start), 0);
        chk("single_rdy2", 32'(start_rdy), 1);
        fc2_done = 1;
        tick();
        fc2_done = 0;
        chk("single_frame_done", 32'(frame_done), 1);
        tick();
        chk("single_fd_pulse", 32'(frame_done), 0);

        // overlap: frame B (mode 0) while L2 works on frame A (mode 1)
        start = 1; mode_in = 1;
        tick();
        start = 0;
        fc1_done = 1;
        tick();
        fc1_done = 0;
        #1;
        chk("ovl_a_fc2_start", 32'(fc2_start), 1);
        tick();
        start = 1; mode_in = 0;
        #1;
        chk("ovl_b_rdy", 32'(start_rdy), 1);
        tick();
        start = 0;
        chk("ovl_b_fc1_mode", 32'(fc1_mode), 0);
        fc1_done = 1;
        tick();
        fc1_done = 0;
        #1;
        chk("ovl_slot_full", 32'(start_rdy), 0);
        chk("ovl_no_fc2", 32'(fc2_start), 0);
        tick();
        chk("ovl_slot_hold", 32'(start_rdy), 0);
        fc2_done = 1;
        tick();
        fc2_done = 0;
        #1;
        chk("ovl_a_done", 32'(frame_done), 1);
        chk("ovl_b_fc2_start", 32'(fc2_start), 1);
        chk("ovl_b_fc2_mode", 32'(fc2_mode), 0);
        tick();
        chk("ovl_rdy_back", 32'(start_rdy), 1);
        fc2_done = 1;
        tick();
        fc2_done = 0;
        chk("ovl_b_done", 32'(frame_done), 1);

        // done pulses while both FSMs idle are ignored
        tick();
        fc1_done = 1; fc2_done = 1;
        tick();
        fc1_done = 0; fc2_done = 0;
        #1;
        chk("idle_done_fc2", 32'(fc2_start), 0);
        chk("idle_done_fd", 32'(frame_done), 0);
        chk("idle_done_rdy", 32'(start_rdy), 1);

        // randomized frame flow: modes must come out of L2 in start order
        n_start = 0; n_done = 0; l1b = 0; l2b = 0; c1 = 0; c2 = 0;
        for (int k = 0; k < 3000 && n_done < 8; k++) begin
            tick();
            if (fc1_start) begin
                chk("rf_fc1_mode", 32'(fc1_mode), 32'(mq[$]));
                l1b = 1;
                c1 = $urandom_range(0, 5);
            end
            if (frame_done) n_done++;
            start = 0; fc1_done = 0; fc2_done = 0;
            if (l1b) begin
                if (c1 == 0) begin fc1_done = 1; l1b = 0; end
                else c1--;
            end
            if (l2b) begin
                if (c2 == 0) begin fc2_done = 1; l2b = 0; end
                else c2--;
            end
            #1;
            if (start_rdy && n_start < 8 && $urandom_range(0, 1) == 1) begin
                m = 1'($urandom);
                mode_in = m;
                start = 1;
                mq.push_back(m);
                n_start++;
            end
            if (fc2_start) begin
                if (mq.size() == 0) begin
                    chk("rf_spurious_fc2", 32'(fc2_start), 0);
                end else begin
                    chk("rf_fc2_mode", 32'(fc2_mode), 32'(mq.pop_front()));
                end
                l2b = 1;
                c2 = $urandom_range(0, 7);
            end
        end
        start = 0; fc1_done = 0; fc2_done = 0;
        chk("rf_frames_done", 32'(n_done), 8);
        chk("rf_queue_empty", 32'(mq.size()), 0);

        // weight port: 6 cycles of contention, then random traffic
        for (int k = 0; k <= N + LAT + 4; k++) begin
            exp_wen[k] = 0; exp_vld[k] = 0; exp_own[k] = 0;
            exp_wa[k] = '0;
        end
        last_g = 2;
        for (int k = 0; k < N; k++) begin
            tick();
            chk("arb_w_en", 32'(w_en), 32'(exp_wen[k]));
            chk("arb_w_addr", 32'(w_addr), 32'(exp_wa[k]));
            chk("arb_rd_vld", 32'(rd_vld), 32'(exp_vld[k]));
            if (exp_vld[k]) chk("arb_rd_owner", 32'(rd_owner), 32'(exp_own[k]));
            if (k < 6) begin
                req1 = 1; req2 = 1;
            end else begin
                req1 = 1'($urandom); req2 = 1'($urandom);
            end
            addr1 = AW'($urandom); addr2 = AW'($urandom);
            #1;
            g1 = req1 && (!req2 || last_g == 2);
            g2 = req2 && !g1;
            if (k < 6) chk("arb_alternate", 32'(gnt1), 32'(k % 2 == 0));
            chk("arb_gnt1", 32'(gnt1), 32'(g1));
            chk("arb_gnt2", 32'(gnt2), 32'(g2));
            if (g1) last_g = 1;
            if (g2) last_g = 2;
            exp_wen[k+1] = g1 | g2;
            exp_wa[k+1]  = g1 ? addr1 : (g2 ? addr2 : exp_wa[k]);
            if (g1 | g2) begin
                exp_vld[k+1+LAT] = 1;
                exp_own[k+1+LAT] = g2;
            end
        end
        req1 = 0; req2 = 0;

        // reset with three reads in flight and a frame in L1
        repeat (LAT + 2) tick();
        start = 1; mode_in = 1;
        tick();
        start = 0;
        req1 = 1;
        repeat (3) begin
            addr1 = AW'($urandom);
            tick();
        end
        req1 = 0;
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk_reset_vals("midrst");
        for (int k = 0; k < LAT + 3; k++) begin
            tick();
            chk("midrst_no_rd_vld", 32'(rd_vld), 0);
        end

`ifdef FC_LAYER_SCHED_WATCHDOG_EN
        // L1 never finishes: times out after 16 cycles in RUN
        start = 1; mode_in = 1;
        tick();
        start = 0;
        for (int k = 1; k < 16; k++) begin
            chk("wd_running", 32'(start_rdy), 0);
            chk("wd_err_low", 32'(err), 0);
            tick();
        end
        chk("wd_running_last", 32'(start_rdy), 0);
        tick();
        chk("wd_idle", 32'(start_rdy), 1);
        chk("wd_err", 32'(err), 1);
        chk("wd_no_fc2", 32'(fc2_start), 0);
        repeat (3) tick();
        chk("wd_err_sticky", 32'(err), 1);
        chk("wd_no_fc2_late", 32'(fc2_start), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
